// File: rtl/alu_req_driver.sv
// Request FIFO feeding a combinational ALU, one op at a time.
// Each op is issued for one cycle, then its response is held until accepted.
package riscv_32i_control_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
endpackage

module alu_req_driver
    import riscv_32i_control_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  alu_op_t                  req_op,
    input  word_t                    req_a,
    input  word_t                    req_b,
    output alu_op_t                  alu_op,
    output word_t                    alu_in_a,
    output word_t                    alu_in_b,
    output logic                     alu_issue,
    input  word_t                    alu_result,
    input  logic                     alu_zero,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output alu_op_t                  rsp_op,
    output word_t                    rsp_result,
    output logic                     rsp_zero,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        alu_op_t op;
        word_t   a;
        word_t   b;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    req_t           mem [DEPTH];
    req_t           head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count_q;
    logic           push;
    logic           pop;
    logic           fifo_nonempty;

    assign req_ready     = (count_q < (AW+1)'(DEPTH));
    assign push          = req_valid & req_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head          = mem[rd_ptr];
    assign count         = count_q;
    assign alu_issue     = (state_q == ISSUE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = HOLD;
            HOLD: begin
                if (rsp_ready) begin
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage needs no reset: occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: req_op, a: req_a, b: req_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op   <= ALU_ADD;
            alu_in_a <= '0;
            alu_in_b <= '0;
        end else if (pop) begin
            alu_op   <= head.op;
            alu_in_a <= head.a;
            alu_in_b <= head.b;
        end
    end

    // The ALU is combinational, so its outputs are valid at the closing edge of ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_op     <= ALU_ADD;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (state_q == ISSUE) begin
            rsp_valid  <= 1'b1;
            rsp_op     <= alu_op;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
        end else if (state_q == HOLD && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_req_driver;
    import riscv_32i_control_pkg::*;

    localparam int DEPTH = 4;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    req_valid = 1'b0;
    logic    req_ready;
    alu_op_t req_op = ALU_ADD;
    word_t   req_a = '0;
    word_t   req_b = '0;
    alu_op_t alu_op;
    word_t   alu_in_a;
    word_t   alu_in_b;
    logic    alu_issue;
    word_t   alu_result;
    logic    alu_zero;
    logic    rsp_valid;
    logic    rsp_ready = 1'b0;
    alu_op_t rsp_op;
    word_t   rsp_result;
    logic    rsp_zero;
    logic [$clog2(DEPTH):0] count;

    alu_req_driver #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_issue(alu_issue), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic word_t ref_alu(input alu_op_t op, input word_t a, input word_t b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return word_t'($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            default:  return '0;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_op, alu_in_a, alu_in_b);
        alu_zero   = (alu_result == '0);
    end

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%08h want 0x%08h", name, cyc, act, exp);
    endtask

    typedef struct {
        alu_op_t op;
        word_t   a;
        word_t   b;
    } req_s;

    // Model: a queue of waiting requests plus one request in flight.
    // in_flight with waiting_ack=0 means it sits on the ALU ports this cycle.
    req_s    mq[$];
    bit      in_flight;
    bit      waiting_ack;
    alu_op_t m_aop;
    word_t   m_aa, m_ab;
    alu_op_t m_rop;
    word_t   m_rres;
    bit      m_rzero;
    bit      take;
    req_s    e;
    int      hs_cyc[$];
    word_t   hs_res[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            in_flight = 0; waiting_ack = 0;
            m_aop = ALU_ADD; m_aa = '0; m_ab = '0;
            m_rop = ALU_ADD; m_rres = '0; m_rzero = 0;
            check("rst_count", 32'(count), 0);
            check("rst_req_ready", 32'(req_ready), 1);
            check("rst_alu_issue", 32'(alu_issue), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_alu_op", 32'(alu_op), 0);
            check("rst_alu_in_a", alu_in_a, 0);
            check("rst_alu_in_b", alu_in_b, 0);
            check("rst_rsp_op", 32'(rsp_op), 0);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_rsp_zero", 32'(rsp_zero), 0);
        end else begin
            check("count", 32'(count), mq.size());
            check("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
            check("alu_issue", 32'(alu_issue), 32'(in_flight && !waiting_ack));
            check("rsp_valid", 32'(rsp_valid), 32'(in_flight && waiting_ack));
            check("alu_op", 32'(alu_op), 32'(m_aop));
            check("alu_in_a", alu_in_a, m_aa);
            check("alu_in_b", alu_in_b, m_ab);
            if (in_flight && waiting_ack) begin
                check("rsp_op", 32'(rsp_op), 32'(m_rop));
                check("rsp_result", rsp_result, m_rres);
                check("rsp_zero", 32'(rsp_zero), 32'(m_rzero));
            end
            if (rsp_valid && rsp_ready) begin
                hs_cyc.push_back(cyc);
                hs_res.push_back(rsp_result);
            end
            take = req_valid && (mq.size() < DEPTH);
            if (!in_flight) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_aop = e.op; m_aa = e.a; m_ab = e.b;
                    in_flight = 1; waiting_ack = 0;
                end
            end else if (!waiting_ack) begin
                m_rop   = m_aop;
                m_rres  = ref_alu(m_aop, m_aa, m_ab);
                m_rzero = (m_rres == '0);
                waiting_ack = 1;
            end else if (rsp_ready) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_aop = e.op; m_aa = e.a; m_ab = e.b;
                    waiting_ack = 0;
                end else begin
                    in_flight = 0; waiting_ack = 0;
                end
            end
            if (take) mq.push_back('{req_op, req_a, req_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input alu_op_t op, input word_t a, input word_t b);
        bit ok;
        ok = 0;
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = req_ready;
            tick();
        end
        req_valid = 0;
        check("push_accept", 32'(ok), 1);
    endtask

    alu_op_t f_op [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR};
    word_t   f_a  [5] = '{32'h1, 32'hA, 32'hF0, 32'h0F, 32'hFF};
    word_t   f_b  [5] = '{32'h2, 32'h4, 32'h3C, 32'hF0, 32'h0F};
    word_t   f_r  [5] = '{32'h3, 32'h6, 32'h30, 32'hFF, 32'hF0};

    alu_op_t b_op [8] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT,
                          ALU_SLTU, ALU_ADD, ALU_XOR, ALU_SUB};
    word_t   b_a  [8] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                          32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h3};
    word_t   b_b  [8] = '{32'h4, 32'h4, 32'h4, 32'h1,
                          32'h1, 32'h1, 32'h5555_5555, 32'h5};
    word_t   b_r  [8] = '{32'h10, 32'h0800_0000, 32'hF800_0000, 32'h1,
                          32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    initial begin
        int base;

        repeat (3) tick();
        check("reset_count", 32'(count), 0);
        check("reset_req_ready", 32'(req_ready), 1);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        rst_n = 1;

        // single ADD, latency, then backpressure hold
        push(ALU_ADD, 32'h5, 32'h3);
        check("add_count_n", 32'(count), 1);
        check("add_issue_n", 32'(alu_issue), 0);
        tick();
        check("add_issue_n1", 32'(alu_issue), 1);
        check("add_in_a", alu_in_a, 32'h5);
        check("add_in_b", alu_in_b, 32'h3);
        tick();
        check("add_rsp_valid_n2", 32'(rsp_valid), 1);
        check("add_rsp_result", rsp_result, 32'h8);
        check("add_rsp_zero", 32'(rsp_zero), 0);
        check("add_rsp_op", 32'(rsp_op), 32'(ALU_ADD));
        repeat (5) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_result", rsp_result, 32'h8);
            check("hold_issue", 32'(alu_issue), 0);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("add_ack_clears", 32'(rsp_valid), 0);

        // zero flag
        push(ALU_SUB, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        tick();
        check("sub_valid", 32'(rsp_valid), 1);
        check("sub_result", rsp_result, 32'h0);
        check("sub_zero", 32'(rsp_zero), 1);
        check("sub_op", 32'(rsp_op), 32'(ALU_SUB));
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // full FIFO, sixth request refused, then ordered drain
        for (int i = 0; i < 5; i++) push(f_op[i], f_a[i], f_b[i]);
        check("full_count", 32'(count), DEPTH);
        check("full_ready", 32'(req_ready), 0);
        req_valid = 1; req_op = ALU_ADD; req_a = 32'h99; req_b = 32'h1;
        repeat (3) begin
            tick();
            check("full_refuse_count", 32'(count), DEPTH);
        end
        req_valid = 0;
        base = hs_res.size();
        rsp_ready = 1;
        for (int i = 0; i < 30 && hs_res.size() < base + 5; i++) tick();
        rsp_ready = 0;
        repeat (4) tick();
        check("drain_total", hs_res.size() - base, 5);
        for (int i = 0; i < 5; i++)
            if (base + i < hs_res.size())
                check($sformatf("drain_%0d", i), hs_res[base + i], f_r[i]);

        // back-to-back with the consumer always ready
        base = hs_res.size();
        rsp_ready = 1;
        for (int i = 0; i < 8; i++) push(b_op[i], b_a[i], b_b[i]);
        for (int i = 0; i < 40 && hs_res.size() < base + 8; i++) tick();
        tick();
        rsp_ready = 0;
        check("b2b_total", hs_res.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < hs_res.size())
                check($sformatf("b2b_res_%0d", i), hs_res[base + i], b_r[i]);
        for (int i = 0; i < 7; i++)
            if (base + i + 1 < hs_cyc.size())
                check($sformatf("b2b_gap_%0d", i),
                      hs_cyc[base + i + 1] - hs_cyc[base + i], 2);

        // reset during ISSUE with three requests queued
        for (int i = 0; i < 5; i++) push(f_op[i], f_a[i], f_b[i]);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("mid_issue", 32'(alu_issue), 1);
        check("mid_count", 32'(count), 3);
        #2 rst_n = 0;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_issue", 32'(alu_issue), 0);
        check("mid_rst_ready", 32'(req_ready), 1);
        repeat (2) tick();
        rst_n = 1;
        base = hs_res.size();
        rsp_ready = 1;
        repeat (10) begin
            tick();
            check("no_stale_valid", 32'(rsp_valid), 0);
        end
        rsp_ready = 0;
        check("no_stale_hs", hs_res.size() - base, 0);
        push(ALU_OR, 32'h100, 32'h001);
        tick();
        tick();
        check("post_rst_result", rsp_result, 32'h101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_req_driver.md
ALU_REQ_DRIVER -- requirements
Module: alu_req_driver

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving request FIFO depth; legal values are powers of 2 and at least 2.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset (one clock; reset asynchronous and active-low).
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  request FIFO can accept.
REQ-006 req_op  input  alu_op_t  requested ALU operation (riscv_32i_control_pkg).
REQ-007 req_a, req_b  input  word_t (32)  requested operands.
REQ-008 alu_op  output  alu_op_t  operation driven to the ALU.
REQ-009 alu_in_a, alu_in_b  output  word_t  operands driven to the ALU.
REQ-010 alu_issue  output  1  high while the ALU ports carry the operation being sampled.
REQ-011 alu_result  input  word_t  combinational ALU result.
REQ-012 alu_zero  input  1  combinational ALU zero flag.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_op  output  alu_op_t  echo of the issued operation.
REQ-016 rsp_result  output  word_t  captured alu_result.
REQ-017 rsp_zero  output  1  captured alu_zero.
REQ-018 count  output  $clog2(DEPTH)+1  current request FIFO occupancy.

Function
REQ-019 Request push occurs on an edge where req_valid and req_ready are both 1; the FIFO stores {req_op, req_a, req_b} in order.
REQ-020 req_ready SHALL be (count < DEPTH), driven from registered state, with no same-cycle pop bypass when full.
REQ-021 A simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 FSM states: IDLE, ISSUE, HOLD.
REQ-023 IDLE: if count > 0, pop the head into the alu_* output registers and go to ISSUE; otherwise stay.
REQ-024 ISSUE: alu_issue = 1 for exactly one cycle; at the closing edge, capture alu_result, alu_zero and the issued op into rsp_* and set rsp_valid; go to HOLD.
REQ-025 HOLD: rsp_valid = 1 and all rsp_* outputs stay stable until a rsp_valid & rsp_ready edge.
REQ-026 On the HOLD handshake edge, clear rsp_valid; if count > 0, pop the next entry into alu_* and go to ISSUE, else go to IDLE.
REQ-027 alu_op, alu_in_a and alu_in_b SHALL hold their last driven values outside ISSUE; alu_issue = 0 outside ISSUE.
REQ-028 Latency: a request pushed into an empty FIFO while in IDLE at edge N SHALL produce rsp_valid = 1 after edge N+2.
REQ-029 Throughput: with rsp_ready held at 1 and the FIFO non-empty, one response SHALL complete every 2 cycles.
REQ-030 Responses SHALL come out in request order, one per request, with none dropped or duplicated.
REQ-031 The pop at REQ-023 and REQ-026 SHALL combine with a same-edge push per REQ-021.

Reset
REQ-032 While rst_n = 0: state = IDLE, FIFO empty, pointers = 0, count = 0, and req_ready = 1 once the FIFO is empty.
REQ-033 While rst_n = 0: alu_op, alu_in_a, alu_in_b, rsp_op, rsp_result = 0; alu_issue, rsp_valid, rsp_zero = 0.
REQ-034 Reset asserted mid-operation SHALL asynchronously discard all queued and in-flight requests and deassert rsp_valid immediately.
REQ-035 Reset deassertion SHALL be synchronised by the user, and the first push SHALL be accepted on the first edge after release.

Verification
REQ-036 Single ADD: push op=ADD, a=0x0000_0005, b=0x0000_0003 into an idle block -> alu_issue high one cycle later; rsp_valid after edge N+2 with rsp_result=0x8, rsp_zero=0.
REQ-037 Zero flag: push SUB with a=b=0xDEAD_BEEF -> rsp_result=0x0, rsp_zero=1, rsp_op=SUB.
REQ-038 Full FIFO: hold rsp_ready=0 and push 6 requests with DEPTH=4 -> 1 request is issued, 4 are queued, req_ready=0, count=4; releasing rsp_ready drains all 5 in order.
REQ-039 Back-to-back: 8 requests with rsp_ready=1 -> rsp_valid pulses every 2 cycles; results match a reference ALU model in order.
REQ-040 Backpressure stability: hold rsp_ready=0 for 5 cycles in HOLD -> rsp_* constant and alu_issue=0 throughout.
REQ-041 Reset mid-flight: assert rst_n=0 during ISSUE with 3 queued -> count=0, rsp_valid=0 at once; after release, no stale response appears.
